// File: rtl/msdap_pkg.sv
// Shared constants for the MSDAP serial input stage.
// Holds the default word geometry and the receiver state encoding.
package msdap_pkg;

  localparam int DATA_W_DEF     = 16;
  localparam int ZERO_LIMIT_DEF = 800;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

endpackage

// File: rtl/sipo_shift_chan.sv
// One serial channel: MSB-first shift register with a parallel load into the output word.
// All strobes come from the shared receiver FSM in sipo_stereo_rx.
module sipo_shift_chan
  import msdap_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              start,
  input  logic              shift_en,
  input  logic              load,
  input  logic              din,
  output logic [DATA_W-1:0] word,
  output logic              next_zero
);

  logic [DATA_W-1:0] shift_r;
  logic [DATA_W-1:0] next_word_s;

  // word completed by the bit currently on din
  always_comb begin
    next_word_s = {shift_r[DATA_W-2:0], din};
    next_zero   = (next_word_s == {DATA_W{1'b0}});
  end

  // shift register and delivered word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_r <= {DATA_W{1'b0}};
      word    <= {DATA_W{1'b0}};
    end else begin
      if (clr) begin
        shift_r <= {DATA_W{1'b0}};
      end else if (start) begin
        shift_r <= {{(DATA_W-1){1'b0}}, din};
      end else if (shift_en || load) begin
        shift_r <= next_word_s;
      end else begin
        shift_r <= shift_r;
      end
      if (load) begin
        word <= next_word_s;
      end else begin
        word <= word;
      end
    end
  end

endmodule

// File: rtl/sipo_stereo_rx.sv
// Stereo serial-to-parallel receiver: frame-aligned deserialisation, valid/ack handshake,
// overrun and framing error pulses, and all-zero run (sleep) detection.
module sipo_stereo_rx
  import msdap_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ZERO_LIMIT = ZERO_LIMIT_DEF
) (
  input  logic              Sclk,
  input  logic              clear_n,
  input  logic              s2p_enable,
  input  logic              Frame,
  input  logic              InputL,
  input  logic              InputR,
  output logic [DATA_W-1:0] data_L,
  output logic [DATA_W-1:0] data_R,
  output logic              data_valid,
  input  logic              data_ack,
  output logic              overrun,
  output logic              frame_err,
  output logic              sleep_flag
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam int ZC_W  = $clog2(ZERO_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_START = CNT_W'(DATA_W - 2);
  localparam logic [ZC_W-1:0]  ZC_MAX    = ZC_W'(ZERO_LIMIT);

  logic [0:0]       state_r, state_nxt_s;
  logic [CNT_W-1:0] bit_cnt_r, bit_cnt_nxt_s;
  logic [ZC_W-1:0]  zero_cnt_r, zero_cnt_nxt_s;
  logic             start_s, shift_s, load_s, clr_s, ferr_s;
  logic             zero_l_s, zero_r_s;

  sipo_shift_chan #(.DATA_W(DATA_W)) u_chan_l (
    .clk(Sclk), .rst_n(clear_n), .clr(clr_s), .start(start_s), .shift_en(shift_s),
    .load(load_s), .din(InputL), .word(data_L), .next_zero(zero_l_s)
  );

  sipo_shift_chan #(.DATA_W(DATA_W)) u_chan_r (
    .clk(Sclk), .rst_n(clear_n), .clr(clr_s), .start(start_s), .shift_en(shift_s),
    .load(load_s), .din(InputR), .word(data_R), .next_zero(zero_r_s)
  );

  // receiver FSM: a Frame always restarts the word, even mid-word or on the LSB edge
  always_comb begin
    state_nxt_s   = state_r;
    bit_cnt_nxt_s = bit_cnt_r;
    start_s       = 1'b0;
    shift_s       = 1'b0;
    load_s        = 1'b0;
    clr_s         = 1'b0;
    ferr_s        = 1'b0;
    if (!s2p_enable) begin
      state_nxt_s   = ST_IDLE;
      bit_cnt_nxt_s = {CNT_W{1'b0}};
      clr_s         = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (Frame) begin
            start_s       = 1'b1;
            bit_cnt_nxt_s = CNT_START;
            state_nxt_s   = ST_SHIFT;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_SHIFT: begin
          if (Frame) begin
            ferr_s        = 1'b1;
            start_s       = 1'b1;
            bit_cnt_nxt_s = CNT_START;
          end else if (bit_cnt_r != {CNT_W{1'b0}}) begin
            shift_s       = 1'b1;
            bit_cnt_nxt_s = bit_cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            load_s      = 1'b1;
            state_nxt_s = ST_IDLE;
          end
        end
        default: begin
          state_nxt_s   = ST_IDLE;
          bit_cnt_nxt_s = {CNT_W{1'b0}};
          clr_s         = 1'b1;
        end
      endcase
    end
  end

  // zero-run count as it will stand after a completed pair
  always_comb begin
    if (zero_l_s && zero_r_s) begin
      if (zero_cnt_r == ZC_MAX) begin
        zero_cnt_nxt_s = zero_cnt_r;
      end else begin
        zero_cnt_nxt_s = zero_cnt_r + {{(ZC_W-1){1'b0}}, 1'b1};
      end
    end else begin
      zero_cnt_nxt_s = {ZC_W{1'b0}};
    end
  end

  // state, handshake, status pulses and zero-run tracking
  always_ff @(posedge Sclk or negedge clear_n) begin
    if (!clear_n) begin
      state_r    <= ST_IDLE;
      bit_cnt_r  <= {CNT_W{1'b0}};
      zero_cnt_r <= {ZC_W{1'b0}};
      data_valid <= 1'b0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
      sleep_flag <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      bit_cnt_r <= bit_cnt_nxt_s;
      frame_err <= ferr_s;
      if (load_s) begin
        data_valid <= 1'b1;
        overrun    <= data_valid & ~data_ack;
        zero_cnt_r <= zero_cnt_nxt_s;
        sleep_flag <= (zero_cnt_nxt_s == ZC_MAX);
      end else begin
        data_valid <= data_valid & ~data_ack;
        overrun    <= 1'b0;
        zero_cnt_r <= zero_cnt_r;
        sleep_flag <= sleep_flag;
      end
    end
  end

endmodule

// File: tb/tb_sipo_stereo_rx.sv
// Self-checking bench for sipo_stereo_rx: expected word pairs are queued as each word
// is driven and compared against the DUT once its LSB edge has passed.
module tb_sipo_stereo_rx;

  localparam int DW = 16;
  localparam int ZL = 4;

  typedef struct {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
    logic          sleep;
  } exp_t;

  logic          Sclk = 1'b0;
  logic          clear_n = 1'b0;
  logic          s2p_enable = 1'b0;
  logic          Frame = 1'b0;
  logic          InputL = 1'b0;
  logic          InputR = 1'b0;
  logic          data_ack = 1'b0;
  logic [DW-1:0] data_L, data_R;
  logic          data_valid, overrun, frame_err, sleep_flag;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   ovr_cnt = 0;
  int   ferr_cnt = 0;
  int   zc_model = 0;
  logic valid_model = 1'b0;
  int   ovr_model = 0;
  int   ovr_base, ferr_base;
  exp_t sb_q[$];

  sipo_stereo_rx #(.DATA_W(DW), .ZERO_LIMIT(ZL)) dut (
    .Sclk(Sclk), .clear_n(clear_n), .s2p_enable(s2p_enable), .Frame(Frame),
    .InputL(InputL), .InputR(InputR), .data_L(data_L), .data_R(data_R),
    .data_valid(data_valid), .data_ack(data_ack), .overrun(overrun),
    .frame_err(frame_err), .sleep_flag(sleep_flag)
  );

  always #5 Sclk = ~Sclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // one bit period: drive, take the edge, then sample the single-cycle pulses
  task automatic step(input logic f, input logic l, input logic r, input logic ack);
    Frame = f; InputL = l; InputR = r; data_ack = ack;
    @(posedge Sclk);
    #1;
    Frame = 1'b0; data_ack = 1'b0;
    if (overrun)   ovr_cnt++;
    if (frame_err) ferr_cnt++;
  endtask

  task automatic ack_only();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    valid_model = 1'b0;
    chk("ack_clears", data_valid, 1'b0);
  endtask

  task automatic send_word(input logic [DW-1:0] l, input logic [DW-1:0] r, input logic ack_lsb);
    exp_t e, got_e;
    if (l == '0 && r == '0) zc_model = (zc_model < ZL) ? zc_model + 1 : ZL;
    else                    zc_model = 0;
    e.l = l; e.r = r; e.sleep = (zc_model == ZL);
    sb_q.push_back(e);
    if (valid_model && !ack_lsb) ovr_model++;
    for (int i = DW - 1; i >= 0; i--) begin
      if (i == 0) chk("valid_before_lsb", data_valid, valid_model);
      step(i == DW - 1, l[i], r[i], (i == 0) && ack_lsb);
    end
    valid_model = 1'b1;
    got_e = sb_q.pop_front();
    chk("data_L", data_L, got_e.l);
    chk("data_R", data_R, got_e.r);
    chk("data_valid", data_valid, 1'b1);
    chk("sleep_flag", sleep_flag, got_e.sleep);
  endtask

  initial begin
    logic [DW-1:0] w;
    #2;
    chk("rst_data_L", data_L, 16'h0000);
    chk("rst_data_R", data_R, 16'h0000);
    chk("rst_valid", data_valid, 1'b0);
    chk("rst_flags", {overrun, frame_err, sleep_flag}, 3'b000);
    @(negedge Sclk);
    clear_n = 1'b1;
    s2p_enable = 1'b1;
    @(posedge Sclk);
    #1;

    // 1: basic word pair and latency
    send_word(16'hA5C3, 16'h1234, 1'b0);
    ack_only();

    // 2: back-to-back words, overrun then same-edge ack
    ovr_base = ovr_cnt;
    send_word(16'h0001, 16'h00F0, 1'b0);
    send_word(16'hFFFF, 16'h0F0F, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("overrun_once", ovr_cnt - ovr_base, 1);
    ack_only();
    ovr_base = ovr_cnt;
    send_word(16'h0001, 16'h00F0, 1'b0);
    send_word(16'hFFFF, 16'h0F0F, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("no_overrun_with_ack", ovr_cnt - ovr_base, 0);
    chk("valid_after_ack_load", data_valid, 1'b1);
    ack_only();

    // 3: Frame re-asserted after 7 bits
    ferr_base = ferr_cnt;
    w = 16'h7E3C;
    for (int i = DW - 1; i > DW - 8; i--) step(i == DW - 1, w[i], w[i], 1'b0);
    send_word(16'h8001, 16'h4002, 1'b0);
    chk("frame_err_once", ferr_cnt - ferr_base, 1);
    ack_only();

    // 4: zero run reaches sleep, then a nonzero pair clears it
    for (int k = 0; k < ZL; k++) send_word(16'h0000, 16'h0000, 1'b0);
    chk("sleep_set", sleep_flag, 1'b1);
    send_word(16'h0001, 16'h0000, 1'b1);
    chk("sleep_clear", sleep_flag, 1'b0);
    ack_only();

    // 5: enable dropped mid-word, Frame while disabled is ignored
    ferr_base = ferr_cnt;
    w = 16'hFFFF;
    for (int i = DW - 1; i > DW - 9; i--) step(i == DW - 1, w[i], w[i], 1'b0);
    s2p_enable = 1'b0;
    step(1'b1, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 12; k++) step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("no_valid_from_abort", data_valid, 1'b0);
    s2p_enable = 1'b1;
    send_word(16'h5555, 16'hAAAA, 1'b0);
    chk("no_frame_err_abort", ferr_cnt - ferr_base, 0);

    // 6: async reset mid-word
    w = 16'hC3C3;
    for (int i = DW - 1; i > DW - 6; i--) step(i == DW - 1, w[i], w[i], 1'b0);
    clear_n = 1'b0;
    #1;
    chk("clr_data_L", data_L, 16'h0000);
    chk("clr_data_R", data_R, 16'h0000);
    chk("clr_status", {data_valid, overrun, frame_err, sleep_flag}, 4'b0000);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    clear_n = 1'b1;
    valid_model = 1'b0;
    zc_model = 0;
    for (int k = 0; k < 20; k++) step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("no_word_without_frame", data_valid, 1'b0);
    send_word(16'h1357, 16'h2468, 1'b0);

    chk("overrun_total", ovr_cnt, ovr_model);
    chk("scoreboard_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
